// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline hazard/flush controller. A Moore FSM picks stall,
//                branch flush, exception flush or full flush and counts events.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  iID_ra_addr,
    input  logic [4:0]  iID_rb_addr,
    input  logic        iID_uses_ra,
    input  logic        iID_uses_rb,
    input  logic [4:0]  mREG2_write_reg_addr,
    input  logic        mREG2_do_dm_read,
    input  logic        iEX_branch_taken,
    input  logic        oREG3_alu_overflow,
    input  logic        iFlush_all,
    output logic        do_hazard,
    output logic        do_flush_REG1,
    output logic        do_flush_REG2,
    output logic        do_flush_REG3,
    output logic        do_flush_REG4,
    output logic [15:0] oStall_count,
    output logic [15:0] oFlush_count
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        LDUSE = 3'd1,
        BRF   = 3'd2,
        EXC1  = 3'd3,
        EXC2  = 3'd4,
        FALL  = 3'd5
    } state_t;

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    state_t r_state;
    state_t w_nextState;
    logic   w_loadUse;
    logic   w_countFlush;

    always_comb begin
        w_loadUse = mREG2_do_dm_read && (mREG2_write_reg_addr != 5'd0) &&
                    ((iID_uses_ra && (iID_ra_addr == mREG2_write_reg_addr)) ||
                     (iID_uses_rb && (iID_rb_addr == mREG2_write_reg_addr)));
    end

    // Branch outranks load-use: the stalled decode instruction is flushed anyway.
    always_comb begin
        w_nextState = RUN;
        case (r_state)
            EXC1:    w_nextState = iFlush_all ? FALL : EXC2;
            EXC2:    w_nextState = iFlush_all ? FALL : RUN;
            default: begin
                if (iFlush_all)              w_nextState = FALL;
                else if (oREG3_alu_overflow) w_nextState = EXC1;
                else if (iEX_branch_taken)   w_nextState = BRF;
                else if (w_loadUse)          w_nextState = LDUSE;
                else                         w_nextState = RUN;
            end
        endcase
    end

    always_comb begin
        w_countFlush = (w_nextState == BRF) || (w_nextState == EXC1) ||
                       (w_nextState == FALL);
    end

    // Outputs are registered from the next state so they settle right after posedge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= RUN;
            do_hazard     <= 1'b0;
            do_flush_REG1 <= 1'b0;
            do_flush_REG2 <= 1'b0;
            do_flush_REG3 <= 1'b0;
            do_flush_REG4 <= 1'b0;
            oStall_count  <= 16'd0;
            oFlush_count  <= 16'd0;
        end else begin
            r_state       <= w_nextState;
            do_hazard     <= (w_nextState == LDUSE);
            do_flush_REG1 <= (w_nextState == BRF) || (w_nextState == EXC1) ||
                             (w_nextState == EXC2) || (w_nextState == FALL);
            do_flush_REG2 <= (w_nextState == BRF) || (w_nextState == EXC1) ||
                             (w_nextState == EXC2) || (w_nextState == FALL);
            do_flush_REG3 <= (w_nextState == EXC1) || (w_nextState == FALL);
            do_flush_REG4 <= (w_nextState == FALL);
            if ((w_nextState == LDUSE) && (oStall_count != C_CNT_MAX)) begin
                oStall_count <= oStall_count + 16'd1;
            end
            if (w_countFlush && (oFlush_count != C_CNT_MAX)) begin
                oFlush_count <= oFlush_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl using a queued scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int S_RUN = 0, S_LDUSE = 1, S_BRF = 2, S_EXC1 = 3, S_EXC2 = 4, S_FALL = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  iID_ra_addr, iID_rb_addr, mREG2_write_reg_addr;
    logic        iID_uses_ra, iID_uses_rb, mREG2_do_dm_read;
    logic        iEX_branch_taken, oREG3_alu_overflow, iFlush_all;
    logic        do_hazard, do_flush_REG1, do_flush_REG2, do_flush_REG3, do_flush_REG4;
    logic [15:0] oStall_count, oFlush_count;

    typedef struct packed {
        logic [4:0]  outs;
        logic [15:0] stall;
        logic [15:0] flush;
    } exp_t;

    exp_t expQ[$];
    int   mState, mStall, mFlush;
    int   nTests = 0, nFail = 0;
    bit   chk = 1'b1;

    pipe_ctrl u_dut (
        .clock                (clock),
        .reset                (reset),
        .iID_ra_addr          (iID_ra_addr),
        .iID_rb_addr          (iID_rb_addr),
        .iID_uses_ra          (iID_uses_ra),
        .iID_uses_rb          (iID_uses_rb),
        .mREG2_write_reg_addr (mREG2_write_reg_addr),
        .mREG2_do_dm_read     (mREG2_do_dm_read),
        .iEX_branch_taken     (iEX_branch_taken),
        .oREG3_alu_overflow   (oREG3_alu_overflow),
        .iFlush_all           (iFlush_all),
        .do_hazard            (do_hazard),
        .do_flush_REG1        (do_flush_REG1),
        .do_flush_REG2        (do_flush_REG2),
        .do_flush_REG3        (do_flush_REG3),
        .do_flush_REG4        (do_flush_REG4),
        .oStall_count         (oStall_count),
        .oFlush_count         (oFlush_count)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {hazard, flush4, flush3, flush2, flush1} expected in each state
    function automatic logic [4:0] outsFor(input int s);
        case (s)
            S_LDUSE: return 5'b10000;
            S_BRF:   return 5'b00011;
            S_EXC1:  return 5'b00111;
            S_EXC2:  return 5'b00011;
            S_FALL:  return 5'b01111;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] dutOuts();
        return {do_hazard, do_flush_REG4, do_flush_REG3, do_flush_REG2, do_flush_REG1};
    endfunction

    task automatic setIdle();
        iID_ra_addr = 5'd0; iID_rb_addr = 5'd0; iID_uses_ra = 1'b0; iID_uses_rb = 1'b0;
        mREG2_write_reg_addr = 5'd0; mREG2_do_dm_read = 1'b0;
        iEX_branch_taken = 1'b0; oREG3_alu_overflow = 1'b0; iFlush_all = 1'b0;
    endtask

    task automatic checkZero(input string tag);
        checkVal({tag, "_outs"}, 32'(dutOuts()), 32'd0);
        checkVal({tag, "_stall"}, 32'(oStall_count), 32'd0);
        checkVal({tag, "_flush"}, 32'(oFlush_count), 32'd0);
    endtask

    task automatic doReset();
        @(negedge clock);
        setIdle();
        reset = 1'b1;
        mState = S_RUN; mStall = 0; mFlush = 0;
        @(posedge clock); #1;
        checkZero("reset");
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Drive one cycle of inputs, push the predicted result, then compare after posedge.
    task automatic cycle(input logic [4:0] ra, input logic [4:0] rb, input logic ura,
                         input logic urb, input logic [4:0] wr, input logic rd,
                         input logic br, input logic ov, input logic fa);
        exp_t e, g;
        int   nxt;
        bit   lu;
        @(negedge clock);
        iID_ra_addr = ra; iID_rb_addr = rb; iID_uses_ra = ura; iID_uses_rb = urb;
        mREG2_write_reg_addr = wr; mREG2_do_dm_read = rd;
        iEX_branch_taken = br; oREG3_alu_overflow = ov; iFlush_all = fa;
        lu = rd && (wr != 5'd0) && ((ura && (ra == wr)) || (urb && (rb == wr)));
        if (mState == S_EXC1)      nxt = fa ? S_FALL : S_EXC2;
        else if (mState == S_EXC2) nxt = fa ? S_FALL : S_RUN;
        else if (fa)               nxt = S_FALL;
        else if (ov)               nxt = S_EXC1;
        else if (br)               nxt = S_BRF;
        else if (lu)               nxt = S_LDUSE;
        else                       nxt = S_RUN;
        if (nxt == S_LDUSE && mStall < 65535) mStall++;
        if ((nxt == S_BRF || nxt == S_EXC1 || nxt == S_FALL) && mFlush < 65535) mFlush++;
        mState  = nxt;
        e.outs  = outsFor(nxt);
        e.stall = 16'(mStall);
        e.flush = 16'(mFlush);
        expQ.push_back(e);
        @(posedge clock); #1;
        g = expQ.pop_front();
        if (chk) begin
            checkVal("outs", 32'(dutOuts()), 32'(g.outs));
            checkVal("stall_cnt", 32'(oStall_count), 32'(g.stall));
            checkVal("flush_cnt", 32'(oFlush_count), 32'(g.flush));
            checkVal("excl", 32'(do_hazard & (do_flush_REG1 | do_flush_REG2 |
                                  do_flush_REG3 | do_flush_REG4)), 32'd0);
        end
    endtask

    task automatic idle();
        cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ldUse(input logic [4:0] a, input logic br);
        cycle(a, 5'd0, 1'b1, 1'b0, a, 1'b1, br, 1'b0, 1'b0);
    endtask

    task automatic asyncReset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        checkZero(tag);
        mState = S_RUN; mStall = 0; mFlush = 0;
        @(negedge clock);
        setIdle();
        reset = 1'b0;
    endtask

    initial begin
        setIdle();
        reset = 1'b1;
        mState = S_RUN; mStall = 0; mFlush = 0;
        repeat (2) @(posedge clock);
        #1;
        checkZero("por");
        doReset();

        // Load-use on ra, then on rb, then address 0 and unused operands: no stall.
        ldUse(5'd5, 1'b0);
        checkVal("ld5_hazard", 32'(do_hazard), 32'd1);
        checkVal("ld5_stall", 32'(oStall_count), 32'd1);
        idle();
        checkVal("ld5_one_cycle", 32'(do_hazard), 32'd0);
        ldUse(5'd0, 1'b0);
        checkVal("ld0_stall", 32'(oStall_count), 32'd1);
        cycle(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);

        // Branch together with load-use resolves to a branch flush only.
        doReset();
        ldUse(5'd7, 1'b1);
        checkVal("brlu_outs", 32'(dutOuts()), 32'h03);
        checkVal("brlu_flush", 32'(oFlush_count), 32'd1);
        checkVal("brlu_stall", 32'(oStall_count), 32'd0);
        idle();

        // Overflow: EXC1, EXC2 (branch ignored), RUN.
        doReset();
        cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkVal("exc1_outs", 32'(dutOuts()), 32'h07);
        idle();
        checkVal("exc2_outs", 32'(dutOuts()), 32'h03);
        cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("exc_run_outs", 32'(dutOuts()), 32'h00);
        checkVal("exc_flush", 32'(oFlush_count), 32'd1);

        // Full flush during EXC1, then held.
        doReset();
        cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("fall_outs", 32'(dutOuts()), 32'h0F);
        checkVal("fall_flush", 32'(oFlush_count), 32'd4);
        idle();

        // Back-to-back chaining with no RUN gap.
        ldUse(5'd3, 1'b1);
        ldUse(5'd3, 1'b0);
        cycle(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        ldUse(5'd3, 1'b0);
        ldUse(5'd3, 1'b0);
        idle();

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 14) == 0));
        end

        // Async reset mid-EXC1 and mid-LDUSE.
        doReset();
        cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        asyncReset("areset_exc1");
        idle();
        ldUse(5'd4, 1'b0);
        checkVal("pre_areset_hazard", 32'(do_hazard), 32'd1);
        asyncReset("areset_lduse");
        idle();

        // Stall counter saturation.
        doReset();
        chk = 1'b0;
        for (int i = 0; i < 65534; i++) ldUse(5'd2, 1'b0);
        chk = 1'b1;
        checkVal("sat_preload", 32'(oStall_count), 32'hFFFE);
        repeat (3) ldUse(5'd2, 1'b0);
        checkVal("sat_hold", 32'(oStall_count), 32'hFFFF);
        idle();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL run on one clock with an asynchronous, active-high reset, and SHALL have these ports:
- clock  in  1  single clock; state updates on posedge
- reset  in  1  asynchronous, active-high
- iID_ra_addr  in  5  decode-stage source A register address
- iID_rb_addr  in  5  decode-stage source B register address
- iID_uses_ra  in  1  decode instruction reads ra
- iID_uses_rb  in  1  decode instruction reads rb
- mREG2_write_reg_addr  in  5  execute-stage destination register
- mREG2_do_dm_read  in  1  execute-stage instruction is a load
- iEX_branch_taken  in  1  execute-stage branch/jump resolved taken
- oREG3_alu_overflow  in  1  memory-stage overflow exception
- iFlush_all  in  1  external full pipeline flush request
- do_hazard  out  1  hold REG1, bubble REG2
- do_flush_REG1  out  1  clear REG1
- do_flush_REG2  out  1  clear REG2
- do_flush_REG3  out  1  clear REG3
- do_flush_REG4  out  1  clear REG4
- oStall_count  out  16  cycles spent in load-use stall
- oFlush_count  out  16  flush events taken

Function
REQ-002 The block SHALL sample all inputs on posedge clock and SHALL drive all outputs directly from registered state (Moore), so outputs are stable before the next negedge pipeline-register capture.
REQ-003 The block SHALL contain an FSM with states RUN, LDUSE, BRF, EXC1, EXC2 and FALL.
REQ-004 Load-use SHALL be true when mREG2_do_dm_read=1, mREG2_write_reg_addr!=0, and either (iID_uses_ra=1 and iID_ra_addr==mREG2_write_reg_addr) or (iID_uses_rb=1 and iID_rb_addr==mREG2_write_reg_addr).
REQ-005 From RUN, LDUSE, BRF or FALL, next state SHALL be chosen by fixed priority: iFlush_all -> FALL; else oREG3_alu_overflow -> EXC1; else iEX_branch_taken -> BRF; else load-use -> LDUSE; else RUN.
REQ-006 EXC1 SHALL go to EXC2 and EXC2 SHALL go to RUN, unconditionally except for iFlush_all, which SHALL force FALL from either state.
REQ-007 Outputs per state:
- RUN: all 0
- LDUSE: do_hazard=1 only
- BRF: do_flush_REG1=1 and do_flush_REG2=1 only
- EXC1: do_flush_REG1/2/3=1
- EXC2: do_flush_REG1/2=1
- FALL: all four do_flush_REGx=1, do_hazard=0
REQ-008 do_hazard and any do_flush_REGx SHALL never be 1 in the same cycle.
REQ-009 Each state other than RUN SHALL last exactly one cycle before re-evaluation; back-to-back events SHALL chain states with no intervening RUN cycle.
REQ-010 oStall_count SHALL increment by 1 on each posedge where the next state is LDUSE, and SHALL saturate at 16'hFFFF.
REQ-011 oFlush_count SHALL increment by 1 on each posedge where the next state is BRF, EXC1 or FALL, and SHALL saturate at 16'hFFFF; EXC1->EXC2 SHALL NOT count.
REQ-012 Simultaneous branch and load-use SHALL resolve to BRF, because the stalled decode instruction is flushed anyway; no stall count SHALL be added.

Reset
REQ-013 While reset=1, the state SHALL be RUN, do_hazard and all do_flush_REGx SHALL be 0, and both counters SHALL be 0, regardless of clock.
REQ-014 Reset asserted mid-sequence (e.g. in EXC1) SHALL abort it immediately; after release the FSM SHALL start in RUN with no residual flush.

Verification
REQ-015 Load at mREG2_write_reg_addr=5, iID_ra_addr=5, iID_uses_ra=1 -> do_hazard=1 for exactly one cycle, oStall_count 0->1; repeat with address 0 -> no stall.
REQ-016 iEX_branch_taken=1 together with the load-use condition -> one cycle with do_flush_REG1=do_flush_REG2=1, do_hazard=0, oFlush_count=1, oStall_count=0.
REQ-017 oREG3_alu_overflow=1 pulse -> EXC1 (flush REG1-3), then EXC2 (flush REG1-2), then RUN; oFlush_count +1; a branch during EXC2 is ignored.
REQ-018 iFlush_all=1 during EXC1 -> next cycle all four flushes=1; a second iFlush_all held -> FALL repeated, counter +1 per cycle.
REQ-019 Preload oStall_count to 16'hFFFE via repeated stalls, then 3 more stalls -> counter holds at 16'hFFFF.
REQ-020 Assert reset asynchronously mid-LDUSE -> do_hazard drops without a clock edge, counters read 0.
